irq_ctrl: RTL

Interrupt controller on the consuming side of the timer interrupt interface. It captures rising edges of up to N_SRC level interrupt lines, for example timer o_interrupt outputs, as pending events, and arbitrates them by fixed priority. It presents one request at a time to the host through a req/ack handshake. On acknowledge it pulses a per-source clear back to the originating block, which drives that timer's i_clear.

---
 rtl/irq_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/irq_ctrl.sv
//------------------------------------------------------------------------------
// Module   : irq_ctrl
// Purpose  : Fixed-priority interrupt controller. Captures rising edges of
//            level interrupt lines as pending events, presents one request at
//            a time to the host through a req/ack handshake and pulses a
//            per-source clear back to the serviced source on acknowledge.
// Ports    : i_clk        - system clock
//            i_rst        - asynchronous reset, active-high
//            i_irq        - level interrupt lines (N_SRC)
//            i_mask       - per-source arbitration enable (N_SRC)
//            i_enable     - global enable for issuing new requests
//            i_irq_ack    - host acknowledge of the current request
//            i_ovf_clr    - clears all overflow flags
//            o_irq_req    - request to host
//            o_irq_id     - index of the requesting source (ID_W)
//            o_src_clear  - one-cycle clear pulse to serviced source (N_SRC)
//            o_pending    - pending register (N_SRC)
//            o_overflow   - sticky overflow flags (N_SRC)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module irq_ctrl #(
    parameter int N_SRC = 4,
    parameter int ID_W  = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N_SRC-1:0]  i_irq,
    input  logic [N_SRC-1:0]  i_mask,
    input  logic              i_enable,
    input  logic              i_irq_ack,
    input  logic              i_ovf_clr,
    output logic              o_irq_req,
    output logic [ID_W-1:0]   o_irq_id,
    output logic [N_SRC-1:0]  o_src_clear,
    output logic [N_SRC-1:0]  o_pending,
    output logic [N_SRC-1:0]  o_overflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_CLR  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [N_SRC-1:0]   r_prev;
    logic [N_SRC-1:0]   r_pending;
    logic [N_SRC-1:0]   r_overflow;
    logic [ID_W-1:0]    r_id;
    logic [ID_W-1:0]    w_id_nxt;
    logic [N_SRC-1:0]   w_rise;
    logic [N_SRC-1:0]   w_eligible;
    logic [ID_W-1:0]    w_winner;
    logic [N_SRC-1:0]   w_clr;
    logic [N_SRC-1:0]   w_new_ovf;

    assign w_rise     = i_irq & ~r_prev;
    assign w_eligible = r_pending & i_mask;

    // Lowest set index wins: scan downwards so the last hit is the smallest.
    always_comb begin
        w_winner = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (w_eligible[k]) begin
                w_winner = ID_W'(k);
            end
        end
    end

    // Clear vector is one-hot on the latched id, only in the CLR state.
    always_comb begin
        w_clr = '0;
        if (r_state == S_CLR) begin
            for (int k = 0; k < N_SRC; k++) begin
                if (r_id == ID_W'(k)) begin
                    w_clr[k] = 1'b1;
                end
            end
        end
    end

    // A rise colliding with the service clear is a fresh event, not an overflow.
    assign w_new_ovf = w_rise & r_pending & ~w_clr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev     <= '0;
            r_pending  <= '0;
            r_overflow <= '0;
        end else begin
            r_prev     <= i_irq;
            // Set has priority over the service clear.
            r_pending  <= (r_pending & ~w_clr) | w_rise;
            r_overflow <= (i_ovf_clr ? '0 : r_overflow) | w_new_ovf;
        end
    end

    // FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_id    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_id    <= w_id_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_id_nxt    = r_id;
        case (r_state)
            S_IDLE: begin
                if (i_enable && (w_eligible != '0)) begin
                    w_id_nxt    = w_winner;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                // Mask/enable changes never withdraw an issued request.
                if (i_irq_ack) begin
                    w_state_nxt = S_CLR;
                end
            end
            S_CLR: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_irq_req   = (r_state == S_REQ);
    assign o_irq_id    = r_id;
    assign o_src_clear = w_clr;
    assign o_pending   = r_pending;
    assign o_overflow  = r_overflow;

endmodule

`default_nettype wire
